pixel_reconstruct_multi: RTL
============================

Name: pixel_reconstruct_multi

Overview:
- Parametrised successor to the camera byte-to-pixel reconstructor.
- Samples a parallel DVP camera bus (PCLK/HS/VS/data) in the clk_in domain and assembles BYTES_PER_PIXEL bytes per pixel with runtime-selectable byte order.
- Emits pixel data with h/v coordinates, plus frame-start, line-length and partial-pixel error reporting.
- Sits between the camera pins and the frame buffer/downsampler.

Parameters:
- HCOUNT_WIDTH, 11, width of pixel column counter and line_length_out
- VCOUNT_WIDTH, 10, width of row counter
- DATA_WIDTH, 8, camera bus width
- BYTES_PER_PIXEL, 2, bus samples per pixel; legal 1..4
- SYNC_STAGES, 2, synchroniser depth on all camera inputs; legal 2..3
- PIXEL_WIDTH, DATA_WIDTH*BYTES_PER_PIXEL, derived; not overridden

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-low reset
- camera_pclk_in  in  1  camera pixel clock (asynchronous)
- camera_hs_in  in  1  line valid, high during active bytes
- camera_vs_in  in  1  frame valid, high during active frame
- camera_data_in  in  DATA_WIDTH  camera byte
- swap_in  in  1  0: first byte of a pixel is MSB; 1: first byte is LSB
- decim_en_in  in  1  2x decimation enable (used only with the optional feature)
- pixel_valid_out  out  1  one-cycle strobe, pixel fields valid
- pixel_hcount_out  out  HCOUNT_WIDTH  pixel column
- pixel_vcount_out  out  VCOUNT_WIDTH  pixel row
- pixel_data_out  out  PIXEL_WIDTH  assembled pixel
- frame_start_out  out  1  high with the first pixel_valid_out of a frame
- line_length_out  out  HCOUNT_WIDTH  pixel count of last completed line
- partial_err_out  out  1  one-cycle pulse: line ended with incomplete pixel

Behaviour:
- Reset (rst_in==0 at posedge): all outputs 0, synchroniser flops 0, byte counter 0, internal h/v counters 0. Reset mid-line discards any partial pixel; no error pulse.
- Input path: pclk, hs, vs, data each pass through SYNC_STAGES flops. Sample event = synchronised pclk was 0 last cycle and is 1 now. hs/vs/data are taken from the same stage as pclk, so they stay aligned.
- On a sample with hs&vs high: shift the byte into the assembly register and increment byte_cnt.
  - When byte_cnt reaches BYTES_PER_PIXEL-1, the next clk_in cycle drives pixel_valid_out=1 with pixel_data_out, pixel_hcount_out = current hcount, pixel_vcount_out = current vcount.
  - Then hcount+1, byte_cnt=0.
- Latency: pixel_valid_out rises exactly one clk_in cycle after the sample event of the final byte.
- Byte order: swap_in=0 -> byte k of the pixel lands at bits [PIXEL_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH]. swap_in=1 -> bits [k*DATA_WIDTH +: DATA_WIDTH].
  - swap_in is sampled on byte 0 of each pixel and held for that pixel.
- BYTES_PER_PIXEL==1: every active sample yields a pixel; partial_err_out never fires.
- Line end = sample event with previous sampled hs=1, current hs=0, vs=1. At line end:
  - line_length_out <= hcount
  - vcount+1, hcount=0, byte_cnt=0
  - if byte_cnt!=0, partial_err_out pulses one cycle
- Sample with hs=0 (not a line end): byte_cnt=0.
- vs low at a sample event: hcount, vcount, byte_cnt cleared; partial pixel discarded silently. pixel_*count_out hold their last values; line_length_out holds.
- Frame start: an internal first_pix flag is set while vs is low. frame_start_out is asserted together with the first pixel_valid_out after vs rises, then cleared.
- Wrap: hcount and vcount wrap modulo 2^width; no saturation. line_length_out reports the wrapped value.
- pixel_valid_out, frame_start_out and partial_err_out are otherwise 0. Data and count outputs hold between strobes.

Optional Feature:
- Macro PIXEL_DECIMATE_EN.
- Defined, with decim_en_in=1 (sampled at each vs rising edge, constant for the frame):
  - emit only pixels with even raw column on even raw rows
  - pixel_hcount_out = raw_h>>1, pixel_vcount_out = raw_v>>1
  - line_length_out counts emitted pixels
  - partial_err_out is unaffected
- Defined, with decim_en_in=0: behaviour identical to the base block.
- Not defined: decim_en_in ignored; no decimation logic synthesised.

Decomposition:
- Package pixel_recon_pkg holds:
  - localparam MAX_BYTES_PER_PIXEL=4
  - typedef for the byte-order enum (BYTE_MSB_FIRST, BYTE_LSB_FIRST)
  - function computing the bit slice offset for byte k
- Sub-module cam_input_sync:
  - SYNC_STAGES synchroniser for pclk/hs/vs/data
  - outputs synchronised hs/vs/data and a one-cycle sample_valid strobe
  - reused by future camera blocks

Test Plan:
- BYTES_PER_PIXEL=2, swap_in=0, one line of bytes 0xAB,0xCD,0x12,0x34 -> two strobes, data 0xABCD @h0 then 0x1234 @h1, v0; frame_start_out only with the first; each strobe one clk_in cycle after the final byte's sample event.
- Same bytes with swap_in=1 -> 0xCDAB, 0x3412.
- Line of 5 bytes then hs fall, BPP=2 -> two pixels, partial_err_out pulses once, line_length_out=2, next line starts h0, v1.
- BYTES_PER_PIXEL=3, bytes 0x11,0x22,0x33 -> pixel_data_out=0x112233; vs dropped after 2 bytes of the next pixel -> no strobe, no error, counters zeroed.
- Reset (rst_in=0) asserted mid-pixel, then released and a fresh frame sent -> all outputs 0 during reset; first post-reset pixel at h0/v0 with frame_start_out=1.
- With PIXEL_DECIMATE_EN and decim_en_in=1: 4x4 frame, BPP=1 -> 4 strobes at (0,0),(1,0),(0,1),(1,1) carrying raw pixels (0,0),(2,0),(0,2),(2,2); line_length_out=2.

Source files
------------

// File: rtl/pixel_recon_pkg.sv
// Shared types and helpers for the camera pixel reconstruction blocks.
// Holds the byte-order enum and the bit-slice offset helper for pixel assembly.
package pixel_recon_pkg;

  localparam int MAX_BYTES_PER_PIXEL = 4;

  typedef enum logic {
    BYTE_MSB_FIRST = 1'b0,
    BYTE_LSB_FIRST = 1'b1
  } byte_order_t;

  // Low bit of the slice that byte k of a pixel occupies.
  function automatic int byte_offset(input int k, input byte_order_t order,
                                     input int data_w, input int bpp);
    return (order == BYTE_LSB_FIRST) ? k * data_w : (bpp - 1 - k) * data_w;
  endfunction

endpackage

// File: rtl/pixel_reconstruct_multi_cam_input_sync.sv
// Multi-stage synchroniser for a DVP camera bus with a pclk rising-edge sample strobe.
// hs/vs/data come from the same stage as pclk so they stay aligned with the strobe.
module cam_input_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pclk,
  input  logic                  hs,
  input  logic                  vs,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  hs_sync,
  output logic                  vs_sync,
  output logic [DATA_WIDTH-1:0] data_sync,
  output logic                  sample_valid
);

  logic [SYNC_STAGES-1:0] pclk_sr;
  logic [SYNC_STAGES-1:0] hs_sr;
  logic [SYNC_STAGES-1:0] vs_sr;
  logic [DATA_WIDTH-1:0]  data_sr [SYNC_STAGES];
  logic                   pclk_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pclk_sr   <= '0;
      hs_sr     <= '0;
      vs_sr     <= '0;
      pclk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sr[i] <= '0;
    end else begin
      pclk_sr    <= {pclk_sr[SYNC_STAGES-2:0], pclk};
      hs_sr      <= {hs_sr[SYNC_STAGES-2:0], hs};
      vs_sr      <= {vs_sr[SYNC_STAGES-2:0], vs};
      data_sr[0] <= data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sr[i] <= data_sr[i-1];
      pclk_prev  <= pclk_sr[SYNC_STAGES-1];
    end
  end

  assign hs_sync      = hs_sr[SYNC_STAGES-1];
  assign vs_sync      = vs_sr[SYNC_STAGES-1];
  assign data_sync    = data_sr[SYNC_STAGES-1];
  assign sample_valid = pclk_sr[SYNC_STAGES-1] & ~pclk_prev;

endmodule

// File: rtl/pixel_reconstruct_multi.sv
// DVP camera byte-to-pixel reconstructor: assembles BYTES_PER_PIXEL bytes per pixel with h/v coordinates.
// Optional 2x decimation is compiled in with `define PIXEL_DECIMATE_EN.
module pixel_reconstruct_multi
  import pixel_recon_pkg::*;
#(
  parameter int HCOUNT_WIDTH    = 11,
  parameter int VCOUNT_WIDTH    = 10,
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int SYNC_STAGES     = 2,
  localparam int PIXEL_WIDTH    = DATA_WIDTH * BYTES_PER_PIXEL
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    camera_pclk_in,
  input  logic                    camera_hs_in,
  input  logic                    camera_vs_in,
  input  logic [DATA_WIDTH-1:0]   camera_data_in,
  input  logic                    swap_in,
  input  logic                    decim_en_in,
  output logic                    pixel_valid_out,
  output logic [HCOUNT_WIDTH-1:0] pixel_hcount_out,
  output logic [VCOUNT_WIDTH-1:0] pixel_vcount_out,
  output logic [PIXEL_WIDTH-1:0]  pixel_data_out,
  output logic                    frame_start_out,
  output logic [HCOUNT_WIDTH-1:0] line_length_out,
  output logic                    partial_err_out
);

  localparam int CNT_W = $clog2(MAX_BYTES_PER_PIXEL);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_PIXEL - 1);

  logic                    hs_sync;
  logic                    vs_sync;
  logic [DATA_WIDTH-1:0]   data_sync;
  logic                    sample_valid;

  logic [CNT_W-1:0]        byte_cnt;
  logic [HCOUNT_WIDTH-1:0] hcount;
  logic [VCOUNT_WIDTH-1:0] vcount;
  logic [PIXEL_WIDTH-1:0]  asm_q;
  logic [PIXEL_WIDTH-1:0]  asm_next;
  byte_order_t             order_q;
  byte_order_t             order_eff;
  logic                    hs_prev;
  logic                    first_pix;

  logic                    emit;
  logic [HCOUNT_WIDTH-1:0] h_out;
  logic [VCOUNT_WIDTH-1:0] v_out;
  logic [HCOUNT_WIDTH-1:0] len_out;

  cam_input_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .pclk        (camera_pclk_in),
    .hs          (camera_hs_in),
    .vs          (camera_vs_in),
    .data        (camera_data_in),
    .hs_sync     (hs_sync),
    .vs_sync     (vs_sync),
    .data_sync   (data_sync),
    .sample_valid(sample_valid)
  );

  // Byte order is latched on byte 0 and held for the rest of the pixel.
  always_comb begin
    order_eff = (byte_cnt == '0) ? byte_order_t'(swap_in) : order_q;
    asm_next  = asm_q;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (byte_cnt == CNT_W'(k)) begin
        if (order_eff == BYTE_LSB_FIRST)
          asm_next[byte_offset(k, BYTE_LSB_FIRST, DATA_WIDTH, BYTES_PER_PIXEL) +: DATA_WIDTH] = data_sync;
        else
          asm_next[byte_offset(k, BYTE_MSB_FIRST, DATA_WIDTH, BYTES_PER_PIXEL) +: DATA_WIDTH] = data_sync;
      end
    end
  end

`ifdef PIXEL_DECIMATE_EN
  logic                    decim_q;
  logic [HCOUNT_WIDTH-1:0] hcount_inc;

  // Tracks decim_en_in while vs is low, so the frame uses the value present at vs rise.
  always_ff @(posedge clk_in) begin
    if (!rst_in)       decim_q <= 1'b0;
    else if (!vs_sync) decim_q <= decim_en_in;
  end

  assign hcount_inc = hcount + 1'b1;
  assign emit       = !decim_q || (!hcount[0] && !vcount[0]);
  assign h_out      = decim_q ? (hcount >> 1) : hcount;
  assign v_out      = decim_q ? (vcount >> 1) : vcount;
  assign len_out    = decim_q ? (hcount_inc >> 1) : hcount;
`else
  logic unused_decim;
  assign unused_decim = decim_en_in;
  assign emit         = 1'b1;
  assign h_out        = hcount;
  assign v_out        = vcount;
  assign len_out      = hcount;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pixel_valid_out  <= 1'b0;
      pixel_hcount_out <= '0;
      pixel_vcount_out <= '0;
      pixel_data_out   <= '0;
      frame_start_out  <= 1'b0;
      line_length_out  <= '0;
      partial_err_out  <= 1'b0;
      byte_cnt         <= '0;
      hcount           <= '0;
      vcount           <= '0;
      asm_q            <= '0;
      order_q          <= BYTE_MSB_FIRST;
      hs_prev          <= 1'b0;
      first_pix        <= 1'b1;
    end else begin
      pixel_valid_out <= 1'b0;
      frame_start_out <= 1'b0;
      partial_err_out <= 1'b0;
      if (sample_valid) begin
        hs_prev <= hs_sync;
        if (!vs_sync) begin
          // Outside the frame: drop any partial pixel and arm the frame-start flag.
          byte_cnt  <= '0;
          hcount    <= '0;
          vcount    <= '0;
          first_pix <= 1'b1;
        end else if (hs_sync) begin
          asm_q <= asm_next;
          if (byte_cnt == '0) order_q <= order_eff;
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            hcount   <= hcount + 1'b1;
            if (emit) begin
              pixel_valid_out  <= 1'b1;
              pixel_data_out   <= asm_next;
              pixel_hcount_out <= h_out;
              pixel_vcount_out <= v_out;
              frame_start_out  <= first_pix;
              first_pix        <= 1'b0;
            end
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
          end
        end else begin
          byte_cnt <= '0;
          if (hs_prev) begin
            line_length_out <= len_out;
            vcount          <= vcount + 1'b1;
            hcount          <= '0;
            partial_err_out <= (byte_cnt != '0);
          end
        end
      end
    end
  end

endmodule
